banked_regfile: RTL and testbench
=================================

// Module: banked_regfile
// PURPOSE
//  Parametrised CPU register file: accumulator, stack pointer, IO port register and a banked
//  link-register pair (LX/LY) with one shadow bank for interrupt context. Replaces fixed 8-bit
//  register logic; adds generic width, an interrupt entry/exit FSM and registered IO strobes.
//  Sits between decode/ALU/memory; drives ALU operands A/B and the IO port.
// PARAMETERS
//  WIDTH    8   data width of every register; return address is 2*WIDTH
//  IMM_W    4   immediate width, sign-extended to WIDTH
//  RS_W     2   register-select width; index map fixed: 0=SP, 1=IO, 2=LX, 3=LY
// PORTS
//  clk        in   1         single clock, all state updates on rising edge
//  rst        in   1         synchronous, active-high reset
//  rd         in   1         rd-mode: ACC <= reg[rs] (IO index also pulses ior)
//  wr         in   1         wr-mode: reg[rs] <= ACC (IO index also pulses iow)
//  wa         in   1         ACC <= alu_in
//  isp        in   1         SP <= alu_in; A=SP, B=sext(imm)
//  ljr        in   1         {LY,LX} <= ra (active bank)
//  rs         in   RS_W      register select
//  sel_y      in   1         B operand picks LY (1) or LX (0) when not rd-mode
//  cycle      in   1         second instruction cycle: B=mem_in; 0 marks instruction boundary
//  ra         in   2*WIDTH   jump return address
//  int_ra     in   2*WIDTH   interrupted PC
//  int_req    in   1         level interrupt request
//  ienabled   in   1         global interrupt enable
//  iret       in   1         return-from-interrupt strobe
//  alu_in/mem_in/io_in in WIDTH; imm in IMM_W
//  a_out,b_out out WIDTH     ALU operands (combinational)
//  acc,sp,lx,ly,io_out out WIDTH   architectural views; lx/ly show active bank
//  istatus    out  1         1 while in interrupt context (registered)
//  int_ack    out  1         one-cycle pulse in ENTRY state
//  ior,iow    out  1         one-cycle registered IO strobes
// BEHAVIOUR
//  Reset: all registers, both banks, io_out, ior, iow, int_ack, istatus = 0; FSM -> NORMAL.
//  ACC write: rd has priority over wa; data = reg[rs] (IO index reads io_in) when rd.
//  SP write: wr&&rs==0 (data ACC) or isp (data alu_in); if both, wr wins.
//  LX/LY: wr&&rs==2/3 writes ACC; ljr writes ra; wr wins on same register. Writes go to active
//   bank only (main when istatus=0, shadow when 1). Reads select by istatus.
//  IO: wr&&rs==1 -> io_out<=ACC, iow=1 next cycle for exactly one cycle; rd&&rs==1 -> ior likewise.
//  Operands: A = isp ? SP : ACC. B = isp ? sext(imm) : cycle ? mem_in : (sel_y ? LY : LX).
//  FSM NORMAL -> ENTRY when int_req&&ienabled&&!cycle; ENTRY (1 cycle): shadow {LY,LX}<=int_ra,
//   int_ack=1, istatus<=1 -> ISR. ISR -> EXIT on iret; EXIT (1 cycle): istatus<=0 -> NORMAL.
//  Main bank keeps value throughout ISR. int_req in ISR/EXIT ignored (no nesting); re-sampled
//   in NORMAL, so a held request re-enters one cycle after EXIT.
//  Register writes in ENTRY are still performed to main bank (istatus still 0); int_ra capture
//   overrides any shadow write. In EXIT, writes still target shadow bank.
//  iret outside ISR: ignored. rst in any state: immediate return to NORMAL, istatus=0.
//  Arithmetic: none beyond sign-extension; widths never truncated (ra split LX=low, LY=high).
// STRUCTURE
//  Shared package: register index constants (RS_SP, RS_IO, RS_LX, RS_LY), FSM state enum
//   (NORMAL, ENTRY, ISR, EXIT).
//  One sub-module: link_bank (two WIDTH registers, bank select, write-enable demux, read mux),
//   instantiated once to hold main+shadow LX/LY.
// TESTING
//  rst, then wa with alu_in=0x5A -> acc=0x5A; wr rs=0 -> sp=0x5A next cycle; all others 0.
//  wr rs=1 with acc=0x3C -> io_out=0x3C, iow high exactly 1 cycle; rd rs=1 io_in=0x77 -> acc=0x77, ior pulse.
//  ljr ra=0x1234 -> lx=0x34, ly=0x12; int_req,ienabled,cycle=0, int_ra=0xBEEF -> int_ack pulse,
//   istatus=1, lx=0xEF, ly=0xBE; iret -> istatus=0 after EXIT, lx/ly back to 0x34/0x12.
//  In ISR, int_req held -> no second int_ack; iret with int_req still high -> re-entry in NORMAL+1.
//  int_req while cycle=1 -> entry deferred to next cycle=0; ienabled=0 -> no entry.
//  isp with sp=0x10, imm=4'hF -> a_out=0x10, b_out=0xFF; rst asserted during ISR -> istatus=0, all zero.

Source files
------------

// File: rtl/banked_regfile_pkg.sv
// Shared definitions for the banked register file: register-select index map
// and the interrupt entry/exit state encoding.
package banked_regfile_pkg;

   localparam int RS_SP = 0;
   localparam int RS_IO = 1;
   localparam int RS_LX = 2;
   localparam int RS_LY = 3;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      ENTRY  = 2'd1,
      ISR    = 2'd2,
      EXIT   = 2'd3
   } state_t;

endpackage

// File: rtl/banked_regfile_if.sv
// Decode/ALU/IO-side bus of the register file. The master drives instruction
// controls and data inputs; the slave (register file) drives operands and views.
interface banked_regfile_if #(
   parameter int WIDTH = 8,
   parameter int IMM_W = 4,
   parameter int RS_W  = 2
);
   logic                 rd;
   logic                 wr;
   logic                 wa;
   logic                 isp;
   logic                 ljr;
   logic [RS_W-1:0]      rs;
   logic                 sel_y;
   logic                 cycle;
   logic [2*WIDTH-1:0]   ra;
   logic [2*WIDTH-1:0]   int_ra;
   logic                 int_req;
   logic                 ienabled;
   logic                 iret;
   logic [WIDTH-1:0]     alu_in;
   logic [WIDTH-1:0]     mem_in;
   logic [WIDTH-1:0]     io_in;
   logic [IMM_W-1:0]     imm;

   logic [WIDTH-1:0]     a_out;
   logic [WIDTH-1:0]     b_out;
   logic [WIDTH-1:0]     acc;
   logic [WIDTH-1:0]     sp;
   logic [WIDTH-1:0]     lx;
   logic [WIDTH-1:0]     ly;
   logic [WIDTH-1:0]     io_out;
   logic                 istatus;
   logic                 int_ack;
   logic                 ior;
   logic                 iow;

   modport master (
      output rd, wr, wa, isp, ljr, rs, sel_y, cycle, ra, int_ra,
             int_req, ienabled, iret, alu_in, mem_in, io_in, imm,
      input  a_out, b_out, acc, sp, lx, ly, io_out, istatus, int_ack, ior, iow
   );

   modport slave (
      input  rd, wr, wa, isp, ljr, rs, sel_y, cycle, ra, int_ra,
             int_req, ienabled, iret, alu_in, mem_in, io_in, imm,
      output a_out, b_out, acc, sp, lx, ly, io_out, istatus, int_ack, ior, iow
   );

endinterface

// File: rtl/banked_regfile_link_bank.sv
// LX/LY link-register pair with a main and a shadow bank; bank selects which
// copy is written and which copy is visible.
module link_bank #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bank,
   input  logic               we_x,
   input  logic               we_y,
   input  logic [WIDTH-1:0]   wdata_x,
   input  logic [WIDTH-1:0]   wdata_y,
   input  logic               capture,
   input  logic [2*WIDTH-1:0] cap_data,
   output logic [WIDTH-1:0]   lx,
   output logic [WIDTH-1:0]   ly
);

   logic [WIDTH-1:0] main_x_r;
   logic [WIDTH-1:0] main_y_r;
   logic [WIDTH-1:0] shadow_x_r;
   logic [WIDTH-1:0] shadow_y_r;

   // Bank storage; an interrupt-address capture wins over an ordinary shadow write.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_x_r   <= {WIDTH{1'b0}};
         main_y_r   <= {WIDTH{1'b0}};
         shadow_x_r <= {WIDTH{1'b0}};
         shadow_y_r <= {WIDTH{1'b0}};
      end else begin
         if (we_x && !bank) main_x_r <= wdata_x;
         if (we_y && !bank) main_y_r <= wdata_y;
         if (capture) begin
            shadow_x_r <= cap_data[WIDTH-1:0];
            shadow_y_r <= cap_data[2*WIDTH-1:WIDTH];
         end else begin
            if (we_x && bank) shadow_x_r <= wdata_x;
            if (we_y && bank) shadow_y_r <= wdata_y;
         end
      end
   end

   assign lx = bank ? shadow_x_r : main_x_r;
   assign ly = bank ? shadow_y_r : main_y_r;

endmodule

// File: rtl/banked_regfile.sv
// CPU register file: accumulator, stack pointer, IO port register and banked
// LX/LY link pair, with a one-level interrupt entry/exit sequencer.
module banked_regfile
   import banked_regfile_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IMM_W = 4,
   parameter int RS_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   banked_regfile_if.slave  bus
);

   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] sp_r;
   logic [WIDTH-1:0] io_out_r;
   logic             ior_r;
   logic             iow_r;
   logic             istatus_r;
   logic             int_ack_r;
   state_t           state_r;

   logic [WIDTH-1:0] lx_s;
   logic [WIDTH-1:0] ly_s;
   logic [WIDTH-1:0] rd_data_s;
   logic [WIDTH-1:0] imm_ext_s;
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic             wr_sp_s;
   logic             wr_io_s;
   logic             wr_lx_s;
   logic             wr_ly_s;
   logic             rd_io_s;
   logic             we_x_s;
   logic             we_y_s;
   logic [WIDTH-1:0] wdata_x_s;
   logic [WIDTH-1:0] wdata_y_s;
   logic             capture_s;

   assign wr_sp_s = bus.wr && (bus.rs == RS_W'(RS_SP));
   assign wr_io_s = bus.wr && (bus.rs == RS_W'(RS_IO));
   assign wr_lx_s = bus.wr && (bus.rs == RS_W'(RS_LX));
   assign wr_ly_s = bus.wr && (bus.rs == RS_W'(RS_LY));
   assign rd_io_s = bus.rd && (bus.rs == RS_W'(RS_IO));

   // An explicit register write beats a jump-link on the same register.
   assign we_x_s    = wr_lx_s || bus.ljr;
   assign we_y_s    = wr_ly_s || bus.ljr;
   assign wdata_x_s = wr_lx_s ? acc_r : bus.ra[WIDTH-1:0];
   assign wdata_y_s = wr_ly_s ? acc_r : bus.ra[2*WIDTH-1:WIDTH];
   assign capture_s = (state_r == ENTRY);

   link_bank #(.WIDTH(WIDTH)) u_link_bank (
      .clk      (clk),
      .rst      (rst),
      .bank     (istatus_r),
      .we_x     (we_x_s),
      .we_y     (we_y_s),
      .wdata_x  (wdata_x_s),
      .wdata_y  (wdata_y_s),
      .capture  (capture_s),
      .cap_data (bus.int_ra),
      .lx       (lx_s),
      .ly       (ly_s)
   );

   assign imm_ext_s = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

   // Register read mux for rd-mode; the IO index reads the external port.
   always_comb begin
      rd_data_s = sp_r;
      case (bus.rs)
         RS_W'(RS_SP): rd_data_s = sp_r;
         RS_W'(RS_IO): rd_data_s = bus.io_in;
         RS_W'(RS_LX): rd_data_s = lx_s;
         RS_W'(RS_LY): rd_data_s = ly_s;
         default:      rd_data_s = sp_r;
      endcase
   end

   // ALU operand selection.
   always_comb begin
      a_s = acc_r;
      b_s = lx_s;
      if (bus.isp) begin
         a_s = sp_r;
         b_s = imm_ext_s;
      end else if (bus.cycle) begin
         b_s = bus.mem_in;
      end else if (bus.sel_y) begin
         b_s = ly_s;
      end else begin
         b_s = lx_s;
      end
   end

   // Accumulator, stack pointer, IO port register and one-cycle IO strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r    <= {WIDTH{1'b0}};
         sp_r     <= {WIDTH{1'b0}};
         io_out_r <= {WIDTH{1'b0}};
         ior_r    <= 1'b0;
         iow_r    <= 1'b0;
      end else begin
         if (bus.rd)      acc_r <= rd_data_s;
         else if (bus.wa) acc_r <= bus.alu_in;
         if (wr_sp_s)      sp_r <= acc_r;
         else if (bus.isp) sp_r <= bus.alu_in;
         if (wr_io_s) io_out_r <= acc_r;
         iow_r <= wr_io_s;
         ior_r <= rd_io_s;
      end
   end

   // Interrupt sequencer: one ENTRY cycle swaps to the shadow bank, one EXIT cycle swaps back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= NORMAL;
         istatus_r <= 1'b0;
         int_ack_r <= 1'b0;
      end else begin
         case (state_r)
            NORMAL: begin
               if (bus.int_req && bus.ienabled && !bus.cycle) begin
                  state_r   <= ENTRY;
                  int_ack_r <= 1'b1;
               end else begin
                  int_ack_r <= 1'b0;
               end
            end
            ENTRY: begin
               state_r   <= ISR;
               istatus_r <= 1'b1;
               int_ack_r <= 1'b0;
            end
            ISR: begin
               if (bus.iret) state_r <= EXIT;
               int_ack_r <= 1'b0;
            end
            EXIT: begin
               state_r   <= NORMAL;
               istatus_r <= 1'b0;
               int_ack_r <= 1'b0;
            end
            default: begin
               state_r   <= NORMAL;
               istatus_r <= 1'b0;
               int_ack_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_out   = a_s;
   assign bus.b_out   = b_s;
   assign bus.acc     = acc_r;
   assign bus.sp      = sp_r;
   assign bus.lx      = lx_s;
   assign bus.ly      = ly_s;
   assign bus.io_out  = io_out_r;
   assign bus.istatus = istatus_r;
   assign bus.int_ack = int_ack_r;
   assign bus.ior     = ior_r;
   assign bus.iow     = iow_r;

endmodule

// File: tb/tb_banked_regfile.sv
// Scoreboard bench for banked_regfile: directed scenarios then random traffic,
// each cycle checked against a behavioural model of the register file.
module tb_banked_regfile;

   typedef struct packed {
      logic        rst;
      logic        rd;
      logic        wr;
      logic        wa;
      logic        isp;
      logic        ljr;
      logic [1:0]  rs;
      logic        sel_y;
      logic        cycle;
      logic [15:0] ra;
      logic [15:0] int_ra;
      logic        int_req;
      logic        ienabled;
      logic        iret;
      logic [7:0]  alu_in;
      logic [7:0]  mem_in;
      logic [7:0]  io_in;
      logic [3:0]  imm;
   } stim_t;

   typedef struct packed {
      logic [7:0] acc;
      logic [7:0] sp;
      logic [7:0] lx;
      logic [7:0] ly;
      logic [7:0] io_out;
      logic [7:0] a_out;
      logic [7:0] b_out;
      logic       istatus;
      logic       int_ack;
      logic       ior;
      logic       iow;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sb[$];

   // behavioural model state: register contents per context, context flags
   logic [7:0] m_acc, m_sp, m_io;
   logic [7:0] m_lx[2];
   logic [7:0] m_ly[2];
   bit         m_ctx, m_entering, m_leaving, m_ior, m_iow, m_valid;

   banked_regfile_if #(.WIDTH(8), .IMM_W(4), .RS_W(2)) bus ();

   banked_regfile #(.WIDTH(8), .IMM_W(4), .RS_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.ienabled = 1'b1;
      return s;
   endfunction

   task automatic model_step(input stim_t s);
      logic [7:0] view[4];
      logic [7:0] old_acc;
      int         c;
      if (s.rst) begin
         m_acc = 8'h00; m_sp = 8'h00; m_io = 8'h00;
         m_lx[0] = 8'h00; m_lx[1] = 8'h00; m_ly[0] = 8'h00; m_ly[1] = 8'h00;
         m_ctx = 1'b0; m_entering = 1'b0; m_leaving = 1'b0;
         m_ior = 1'b0; m_iow = 1'b0; m_valid = 1'b1;
      end else begin
         c = m_ctx ? 1 : 0;
         old_acc = m_acc;
         view[0] = m_sp; view[1] = s.io_in; view[2] = m_lx[c]; view[3] = m_ly[c];
         if (s.rd) m_acc = view[s.rs];
         else if (s.wa) m_acc = s.alu_in;
         if (s.wr && s.rs == 2'd0) m_sp = old_acc;
         else if (s.isp) m_sp = s.alu_in;
         if (s.wr && s.rs == 2'd1) m_io = old_acc;
         m_iow = s.wr && s.rs == 2'd1;
         m_ior = s.rd && s.rs == 2'd1;
         if (s.wr && s.rs == 2'd2) m_lx[c] = old_acc;
         else if (s.ljr) m_lx[c] = s.ra[7:0];
         if (s.wr && s.rs == 2'd3) m_ly[c] = old_acc;
         else if (s.ljr) m_ly[c] = s.ra[15:8];
         if (m_entering) begin
            m_lx[1] = s.int_ra[7:0];
            m_ly[1] = s.int_ra[15:8];
            m_ctx = 1'b1;
            m_entering = 1'b0;
         end else if (m_leaving) begin
            m_ctx = 1'b0;
            m_leaving = 1'b0;
         end else if (m_ctx && s.iret) begin
            m_leaving = 1'b1;
         end else if (!m_ctx && s.int_req && s.ienabled && !s.cycle) begin
            m_entering = 1'b1;
         end
      end
   endtask

   task automatic apply(input stim_t s);
      exp_t e;
      int   c;
      @(posedge clk);
      #1;
      cyc++;
      rst          = s.rst;
      bus.rd       = s.rd;       bus.wr     = s.wr;     bus.wa    = s.wa;
      bus.isp      = s.isp;      bus.ljr    = s.ljr;    bus.rs    = s.rs;
      bus.sel_y    = s.sel_y;    bus.cycle  = s.cycle;  bus.ra    = s.ra;
      bus.int_ra   = s.int_ra;   bus.int_req = s.int_req;
      bus.ienabled = s.ienabled; bus.iret   = s.iret;
      bus.alu_in   = s.alu_in;   bus.mem_in = s.mem_in; bus.io_in = s.io_in;
      bus.imm      = s.imm;
      if (m_valid) begin
         c = m_ctx ? 1 : 0;
         e.acc = m_acc; e.sp = m_sp; e.io_out = m_io;
         e.lx = m_lx[c]; e.ly = m_ly[c];
         e.istatus = m_ctx; e.int_ack = m_entering;
         e.ior = m_ior; e.iow = m_iow;
         e.a_out = s.isp ? m_sp : m_acc;
         if (s.isp)        e.b_out = 8'($signed(s.imm));
         else if (s.cycle) e.b_out = s.mem_in;
         else              e.b_out = s.sel_y ? m_ly[c] : m_lx[c];
         sb.push_back(e);
      end
      model_step(s);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // monitor: pop one expectation per cycle and compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("acc", bus.acc, e.acc);
            chk("sp", bus.sp, e.sp);
            chk("lx", bus.lx, e.lx);
            chk("ly", bus.ly, e.ly);
            chk("io_out", bus.io_out, e.io_out);
            chk("a_out", bus.a_out, e.a_out);
            chk("b_out", bus.b_out, e.b_out);
            chk("istatus", {7'd0, bus.istatus}, {7'd0, e.istatus});
            chk("int_ack", {7'd0, bus.int_ack}, {7'd0, e.int_ack});
            chk("ior", {7'd0, bus.ior}, {7'd0, e.ior});
            chk("iow", {7'd0, bus.iow}, {7'd0, e.iow});
         end
      end
   end

   initial begin
      stim_t s;
      m_valid = 1'b0;
      {bus.rd, bus.wr, bus.wa, bus.isp, bus.ljr, bus.sel_y, bus.cycle} = 7'd0;
      {bus.int_req, bus.ienabled, bus.iret} = 3'd0;
      bus.rs = 2'd0; bus.ra = 16'd0; bus.int_ra = 16'd0;
      bus.alu_in = 8'd0; bus.mem_in = 8'd0; bus.io_in = 8'd0; bus.imm = 4'd0;

      s = idle(); s.rst = 1'b1; apply(s);
      apply(idle());
      s = idle(); s.wa = 1'b1; s.alu_in = 8'h5A; apply(s);
      s = idle(); s.wr = 1'b1; s.rs = 2'd0; apply(s);
      s = idle(); s.wa = 1'b1; s.alu_in = 8'h3C; apply(s);
      s = idle(); s.wr = 1'b1; s.rs = 2'd1; apply(s);
      apply(idle());
      s = idle(); s.rd = 1'b1; s.rs = 2'd1; s.io_in = 8'h77; apply(s);
      apply(idle());
      s = idle(); s.ljr = 1'b1; s.ra = 16'h1234; apply(s);
      // interrupt held through the ISR, then iret with request still high
      for (int i = 0; i < 5; i++) begin
         s = idle(); s.int_req = 1'b1; s.int_ra = 16'hBEEF; s.sel_y = i[0]; apply(s);
      end
      s = idle(); s.int_req = 1'b1; s.iret = 1'b1; s.int_ra = 16'hBEEF; apply(s);
      for (int i = 0; i < 4; i++) begin
         s = idle(); s.int_req = 1'b1; s.int_ra = 16'hCAFE; apply(s);
      end
      s = idle(); s.iret = 1'b1; apply(s);
      apply(idle()); apply(idle());
      // second instruction cycle defers entry; disabled interrupts never enter
      s = idle(); s.int_req = 1'b1; s.cycle = 1'b1; s.mem_in = 8'hA5; s.int_ra = 16'h0102; apply(s);
      s = idle(); s.int_req = 1'b1; s.int_ra = 16'h0102; apply(s);
      apply(idle()); apply(idle());
      s = idle(); s.iret = 1'b1; apply(s);
      apply(idle()); apply(idle());
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.int_req = 1'b1; s.ienabled = 1'b0; apply(s);
      end
      s = idle(); s.isp = 1'b1; s.alu_in = 8'h10; apply(s);
      s = idle(); s.isp = 1'b1; s.imm = 4'hF; s.alu_in = 8'h10; apply(s);
      s = idle(); s.isp = 1'b1; s.imm = 4'h7; s.alu_in = 8'h20; apply(s);
      // reset in the middle of an ISR
      s = idle(); s.int_req = 1'b1; s.int_ra = 16'h5566; apply(s);
      apply(idle()); apply(idle());
      s = idle(); s.rst = 1'b1; apply(s);
      apply(idle());

      for (int n = 0; n < 2000; n++) begin
         s.rst      = ($urandom_range(0, 99) == 0);
         s.rd       = ($urandom_range(0, 3) == 0);
         s.wr       = ($urandom_range(0, 2) == 0);
         s.wa       = ($urandom_range(0, 2) == 0);
         s.isp      = ($urandom_range(0, 4) == 0);
         s.ljr      = ($urandom_range(0, 4) == 0);
         s.rs       = 2'($urandom_range(0, 3));
         s.sel_y    = 1'($urandom_range(0, 1));
         s.cycle    = ($urandom_range(0, 3) == 0);
         s.ra       = 16'($urandom);
         s.int_ra   = 16'($urandom);
         s.int_req  = ($urandom_range(0, 3) == 0);
         s.ienabled = ($urandom_range(0, 4) != 0);
         s.iret     = ($urandom_range(0, 4) == 0);
         s.alu_in   = 8'($urandom);
         s.mem_in   = 8'($urandom);
         s.io_in    = 8'($urandom);
         s.imm      = 4'($urandom);
         apply(s);
      end
      apply(idle());

      for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
